// File: rtl/blackjack_pkg.sv
// Shared constants, widths and hand FSM states for the blackjack datapath.
package blackjack_pkg;

  localparam int unsigned CARD_W        = 6;
  localparam int unsigned DECK_SIZE     = 52;
  localparam int unsigned RANK_COUNT    = 13;
  localparam int unsigned VALUE_W       = 4;
  localparam int unsigned SUM_W         = 5;
  localparam int unsigned COUNT_W       = 4;

  localparam int unsigned ACE_RANK      = 0;
  localparam int unsigned LAST_PIP_RANK = 8;
  localparam int unsigned ACE_LOW_VALUE = 1;
  localparam int unsigned FACE_VALUE    = 10;
  localparam int unsigned SOFT_BONUS    = 10;
  localparam int unsigned SOFT_LIMIT    = 11;
  localparam int unsigned BJ_TOTAL      = 21;

  localparam int unsigned MAX_CARDS     = 11;
  localparam int unsigned STAND_ON      = 17;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEAL1,
    ST_DEAL2,
    ST_READY,
    ST_HIT,
    ST_AUTO
  } hand_state_e;

endpackage

// File: rtl/card_value_decode.sv
// Maps a card index (suit*13 + rank) to its blackjack value; aces count as 1.
module card_value_decode
  import blackjack_pkg::*;
(
  input  logic [CARD_W-1:0]  card_idx,
  output logic [VALUE_W-1:0] value,
  output logic               is_ace,
  output logic               invalid
);

  logic [CARD_W-1:0] rank;

  // Rank extraction and value lookup
  always_comb begin
    rank    = card_idx % CARD_W'(RANK_COUNT);
    invalid = (card_idx >= CARD_W'(DECK_SIZE));
    is_ace  = (rank == CARD_W'(ACE_RANK));
    value   = VALUE_W'(FACE_VALUE);
    if (is_ace) begin
      value = VALUE_W'(ACE_LOW_VALUE);
    end else if (rank <= CARD_W'(LAST_PIP_RANK)) begin
      value = VALUE_W'(rank) + VALUE_W'(1);
    end
  end

endmodule

// File: rtl/hand_builder.sv
// Single-hand card consumer: pulls cards from the deck source, tracks the
// soft/hard total and reports bust, blackjack and settle events.
// Optional dealer auto-play is enabled by defining DEALER_AUTO_EN.
module hand_builder
  import blackjack_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               loadFlag,
  input  logic               newHand,
  input  logic               hit,
  input  logic               autoPlay,
  output logic               cardReq,
  input  logic               cardValid,
  input  logic [CARD_W-1:0]  card,
  output logic [SUM_W-1:0]   handTotal,
  output logic               softFlag,
  output logic               bust,
  output logic               blackjack,
  output logic [COUNT_W-1:0] cardCount,
  output logic [CARD_W-1:0]  lastCard,
  output logic               cardErr,
  output logic               busy,
  output logic               done
);

  hand_state_e        state_q, state_d;
  logic               card_req_q, card_req_d;
  logic [SUM_W-1:0]   hard_sum_q, hard_sum_d;
  logic               ace_seen_q, ace_seen_d;
  logic               soft_q, soft_d;
  logic [SUM_W-1:0]   total_q, total_d;
  logic               bust_q, bust_d;
  logic               blackjack_q, blackjack_d;
  logic [COUNT_W-1:0] card_cnt_q, card_cnt_d;
  logic [CARD_W-1:0]  last_card_q, last_card_d;
  logic               card_err_q, card_err_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [VALUE_W-1:0] dec_value;
  logic               dec_is_ace;
  logic               dec_invalid;
  logic               accept;
  logic               take_card;
  logic               hit_ok;

`ifdef DEALER_AUTO_EN
  logic               auto_q, auto_d;
`else
  logic               unused_auto_play;
  assign unused_auto_play = autoPlay;
`endif

  card_value_decode u_decode (
    .card_idx (card),
    .value    (dec_value),
    .is_ace   (dec_is_ace),
    .invalid  (dec_invalid)
  );

  // Next-state, handshake and hand accumulation
  always_comb begin
    state_d     = state_q;
    card_req_d  = card_req_q;
    hard_sum_d  = hard_sum_q;
    ace_seen_d  = ace_seen_q;
    card_cnt_d  = card_cnt_q;
    last_card_d = last_card_q;
    card_err_d  = card_err_q;
    done_d      = 1'b0;
    take_card   = 1'b0;
`ifdef DEALER_AUTO_EN
    auto_d      = auto_q;
`endif
    accept = card_req_q && cardValid && loadFlag;
    hit_ok = !bust_q && (total_q != SUM_W'(BJ_TOTAL)) &&
             (card_cnt_q != COUNT_W'(MAX_CARDS));

    if (newHand) begin
      state_d     = ST_DEAL1;
      card_req_d  = 1'b0;
      hard_sum_d  = '0;
      ace_seen_d  = 1'b0;
      card_cnt_d  = '0;
      last_card_d = '0;
`ifdef DEALER_AUTO_EN
      auto_d      = autoPlay;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          card_req_d = 1'b0;
        end
        ST_DEAL1: begin
          card_req_d = 1'b1;
          if (accept) begin
            if (dec_invalid) begin
              card_err_d = 1'b1;
            end else begin
              take_card = 1'b1;
              state_d   = ST_DEAL2;
            end
          end
        end
        ST_DEAL2: begin
          card_req_d = 1'b1;
          if (accept) begin
            if (dec_invalid) begin
              card_err_d = 1'b1;
            end else begin
              take_card  = 1'b1;
              card_req_d = 1'b0;
              state_d    = ST_READY;
              done_d     = 1'b1;
`ifdef DEALER_AUTO_EN
              if (auto_q) begin
                state_d = ST_AUTO;
                done_d  = 1'b0;
              end
`endif
            end
          end
        end
        ST_READY: begin
          card_req_d = 1'b0;
          if (hit && hit_ok) begin
            state_d = ST_HIT;
          end
        end
        ST_HIT: begin
          card_req_d = 1'b1;
          if (accept) begin
            if (dec_invalid) begin
              card_err_d = 1'b1;
            end else begin
              take_card  = 1'b1;
              card_req_d = 1'b0;
              state_d    = ST_READY;
              done_d     = 1'b1;
            end
          end
        end
`ifdef DEALER_AUTO_EN
        // Request drops after each card so the decision uses the updated total
        ST_AUTO: begin
          if (card_req_q) begin
            if (accept) begin
              if (dec_invalid) begin
                card_err_d = 1'b1;
              end else begin
                take_card  = 1'b1;
                card_req_d = 1'b0;
              end
            end
          end else if ((total_q < SUM_W'(STAND_ON)) && !bust_q) begin
            card_req_d = 1'b1;
          end else begin
            state_d = ST_READY;
            done_d  = 1'b1;
          end
        end
`endif
        default: begin
          state_d    = ST_IDLE;
          card_req_d = 1'b0;
        end
      endcase
    end

    if (take_card) begin
      hard_sum_d  = hard_sum_q + SUM_W'(dec_value);
      ace_seen_d  = ace_seen_q || dec_is_ace;
      card_cnt_d  = card_cnt_q + COUNT_W'(1);
      last_card_d = card;
    end

    soft_d      = ace_seen_d && (hard_sum_d <= SUM_W'(SOFT_LIMIT));
    total_d     = soft_d ? (hard_sum_d + SUM_W'(SOFT_BONUS)) : hard_sum_d;
    bust_d      = (hard_sum_d > SUM_W'(BJ_TOTAL));
    blackjack_d = (card_cnt_d == COUNT_W'(2)) && (total_d == SUM_W'(BJ_TOTAL));
    busy_d      = (state_d inside {ST_DEAL1, ST_DEAL2, ST_HIT, ST_AUTO});
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      card_req_q  <= 1'b0;
      hard_sum_q  <= '0;
      ace_seen_q  <= 1'b0;
      soft_q      <= 1'b0;
      total_q     <= '0;
      bust_q      <= 1'b0;
      blackjack_q <= 1'b0;
      card_cnt_q  <= '0;
      last_card_q <= '0;
      card_err_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef DEALER_AUTO_EN
      auto_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      card_req_q  <= card_req_d;
      hard_sum_q  <= hard_sum_d;
      ace_seen_q  <= ace_seen_d;
      soft_q      <= soft_d;
      total_q     <= total_d;
      bust_q      <= bust_d;
      blackjack_q <= blackjack_d;
      card_cnt_q  <= card_cnt_d;
      last_card_q <= last_card_d;
      card_err_q  <= card_err_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef DEALER_AUTO_EN
      auto_q      <= auto_d;
`endif
    end
  end

  assign cardReq   = card_req_q;
  assign handTotal = total_q;
  assign softFlag  = soft_q;
  assign bust      = bust_q;
  assign blackjack = blackjack_q;
  assign cardCount = card_cnt_q;
  assign lastCard  = last_card_q;
  assign cardErr   = card_err_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: doc/hand_builder.md
# hand_builder

Card consumer for the blackjack datapath. It pulls card indices one at a time from the shuffled-deck source over a request/valid handshake and decodes each to its blackjack value. It accumulates one hand's total with soft-ace handling and reports bust, blackjack and settle events to the game controller. One instance serves the player hand and one serves the dealer hand.

## Interface
- MAX_CARDS, 11, maximum cards per hand; further hits are ignored.
- STAND_ON, 17, auto-play stand threshold; stands on soft totals too.

- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- loadFlag  in  1  deck source shuffled and ready to deal (level)
- newHand  in  1  pulse: clear hand, deal two cards
- hit  in  1  pulse: deal one more card
- autoPlay  in  1  dealer mode request (see Configuration)
- cardReq  out  1  request to deck source
- cardValid  in  1  deck source presents `card`
- card  in  6  card index 0..51 (suit*13 + rank)
- handTotal  out  5  best total
- softFlag  out  1  an ace is currently counted as 11
- bust  out  1  hard sum > 21
- blackjack  out  1  two cards totalling 21
- cardCount  out  4  cards accepted this hand
- lastCard  out  6  most recently accepted index
- cardErr  out  1  sticky: index ≥ 52 received
- busy  out  1  hand dealing in progress
- done  out  1  one-cycle pulse when hand settles

## Operation
- Reset: every output is 0 and the FSM is in IDLE.
- States: IDLE, DEAL1, DEAL2, READY, HIT, AUTO.
- newHand, sampled in any state: clears hardSum, aceSeen, cardCount, lastCard, bust, blackjack and softFlag, then goes to DEAL1. cardErr is cleared only by rst. newHand has priority over a simultaneous hit.
- DEAL1 and DEAL2 accept one card each. DEAL2 goes to AUTO when auto-play is active, else to READY with a done pulse.
- hit in READY goes to HIT, unless bust=1, handTotal==21 or cardCount==MAX_CARDS; in those cases hit is ignored with no cardReq and no done. HIT returns to READY after one card, with a done pulse.
- Card value: rank = card mod 13. Rank 0 (ace) = 1; ranks 1..8 = rank+1; ranks 9..12 = 10.
- Index ≥ 52: the card is accepted, sets cardErr and is otherwise discarded. Counters are unchanged and the FSM stays in the same request state.
- Accumulation:
  - hardSum is 5 bits and sums ace values as 1. aceSeen sets on any ace.
  - softFlag = aceSeen && hardSum ≤ 11.
  - handTotal = hardSum + 10 when softFlag is set, else hardSum.
  - bust = hardSum > 21. The maximum reachable hardSum is 30, so there is no overflow.
  - blackjack = cardCount==2 && handTotal==21.
- busy = 1 in DEAL1, DEAL2, HIT and AUTO.

## Timing
- All outputs are registered.
- cardReq rises on the edge after the FSM enters a request state. It stays high while the FSM is in any request state.
- A card is accepted on a rising edge with cardReq && cardValid && loadFlag. cardValid while cardReq is low is ignored.
- Back-to-back acceptance is allowed: DEAL1 to DEAL2 keeps cardReq high, so a new card can be taken on every edge.
- Hand outputs update on the acceptance edge. cardReq falls on that edge when no further card is needed.
- done is asserted on the edge the FSM enters READY, for exactly one cycle. Latency from newHand to done is at least 3 cycles.
- loadFlag low while requesting: cardReq is held and the FSM waits indefinitely. There is no timeout.
- rst mid-handshake: cardReq drops immediately (asynchronous), and the in-flight card is lost.

## Configuration
- DEALER_AUTO_EN defined:
  - In AUTO, the block requests cards while handTotal < STAND_ON and bust=0.
  - It then goes to READY with a done pulse.
  - autoPlay is sampled with newHand.
- DEALER_AUTO_EN undefined:
  - The AUTO state is not compiled and autoPlay is ignored.
  - DEAL2 always goes to READY.

## Structure
- blackjack_pkg contains:
  - CARD_W = 6 and DECK_SIZE = 52
  - the hand FSM state enum
  - the rank/value constants
- Sub-module card_value_decode: combinational, 6-bit index in; outputs value (4 bits), isAce and invalid.

## Test plan
- newHand, then cards 0 and 12 → handTotal 21, softFlag 1, blackjack 1, cardCount 2, one done pulse.
- Cards 9 and 5 (total 16), then hit with card 6 → handTotal 23, bust 1. A second hit produces no cardReq.
- Cards 0 and 13 (total 12 soft), then hit with card 8 → handTotal 21, softFlag 1, blackjack 0. A further hit is ignored.
- DEALER_AUTO_EN, autoPlay=1:
  - Cards 5 and 0 → stands at soft 17 after 2 cards.
  - Cards 9 and 5, then card 12 → bust at 26 with done.
- cardReq high, cardValid low for 5 cycles → outputs hold. Then card 52 → cardErr 1, cardCount unchanged, cardReq still high.
- Assert rst during DEAL2 → all outputs 0 immediately. The next newHand deals normally.
